alu_pipe: RTL and testbench

Parametrised successor to the team's 8-bit combinational ALU. It keeps the same 16-operation select map and adds:
- a configurable operand width;
- valid/ready handshakes on input and output;
- a registered result with zero, carry and error flags;
- iterative multi-cycle multiply and divide run by an internal state machine.

It sits between an operand source (sequencer or register file) and a result consumer that may apply backpressure.

---
 rtl/alu_pipe.sv | 181 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pipe : handshaked ALU, 16 ops, registered flags, iterative MUL/DIV
// Revision : 1.0
// ----------------------------------------------------------------------------
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_ROL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_NAND = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_GT   = 4'd14;
  localparam logic [3:0] OP_EQ   = 4'd15;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;

  logic               w_accept;
  logic               w_multi;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_err;
  logic [2*WIDTH-1:0] w_acc_nx;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx;
  logic [WIDTH-1:0]   w_iter_res;
  logic               w_iter_c;

  assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  // Divide by zero is resolved in one cycle and never enters BUSY.
  assign w_multi  = (ALU_Sel == OP_MUL) || ((ALU_Sel == OP_DIV) && (B != '0));
  assign w_last   = (r_state == S_BUSY) && (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_multi) w_state_nx = S_BUSY;
      S_BUSY:  if (r_cnt == CW'(1))     w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_err = 1'b0;
    case (ALU_Sel)
      OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_c = w_sum[WIDTH];  end
      OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_c = w_diff[WIDTH]; end
      OP_MUL:  w_res = '0;
      OP_DIV:  begin w_res = '1; w_err = 1'b1; end
      OP_SHL:  begin w_res = {A[WIDTH-2:0], 1'b0}; w_c = A[WIDTH-1]; end
      OP_SHR:  begin w_res = {1'b0, A[WIDTH-1:1]}; w_c = A[0]; end
      OP_ROL:  w_res = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  w_res = {A[0], A[WIDTH-1:1]};
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOR:  w_res = ~(A | B);
      OP_NAND: w_res = ~(A & B);
      OP_XNOR: w_res = ~(A ^ B);
      OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (A == B)};
      default: w_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step per BUSY cycle.
  assign w_acc_nx   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx   = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx   = {r_quo[WIDTH-2:0], w_ge};
  assign w_iter_res = r_is_div ? w_quo_nx : w_acc_nx[WIDTH-1:0];
  assign w_iter_c   = r_is_div ? 1'b0 : (|w_acc_nx[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      ALU_Out   <= '0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      Err       <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_multi) begin
        out_valid <= 1'b0;
        r_cnt     <= CW'(WIDTH);
        r_is_div  <= (ALU_Sel == OP_DIV);
        r_acc     <= '0;
        r_mcand   <= {{WIDTH{1'b0}}, A};
        r_mplier  <= B;
        r_rem     <= '0;
        r_quo     <= A;
        r_div     <= B;
      end else begin
        out_valid <= 1'b1;
        ALU_Out   <= w_res;
        CarryOut  <= w_c;
        Zero      <= (w_res == '0);
        Err       <= w_err;
      end
    end else if (r_state == S_BUSY) begin
      r_cnt    <= r_cnt - CW'(1);
      r_acc    <= w_acc_nx;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_rem    <= w_rem_nx;
      r_quo    <= w_quo_nx;
      if (w_last) begin
        out_valid <= 1'b1;
        ALU_Out   <= w_iter_res;
        CarryOut  <= w_iter_c;
        Zero      <= (w_iter_res == '0);
        Err       <= 1'b0;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_pipe : scoreboard bench for alu_pipe against an arithmetic model
// Revision    : 1.0
// ----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic       err;
    logic       z;
    logic       c;
    logic [7:0] out;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] A, B;
  logic [3:0]       ALU_Sel;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut, Zero, Err, out_valid, out_ready;

  res_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  logic [7:0] tbl_out [16] = '{8'hFF, 8'h55, 8'h72, 8'h02, 8'h54, 8'h55, 8'h55, 8'h55,
                               8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00};
  logic       tbl_c   [16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .in_valid(in_valid), .in_ready(in_ready), .ALU_Out(ALU_Out),
    .CarryOut(CarryOut), .Zero(Zero), .Err(Err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int   ia, ib, r;
    res_t e;
    ia = int'(a);
    ib = int'(b);
    e  = '0;
    r  = 0;
    case (s)
      4'd0:  begin r = ia + ib; e.c = (r > 255); end
      4'd1:  begin r = ia - ib; e.c = (ia < ib); end
      4'd2:  begin r = ia * ib; e.c = (r > 255); end
      4'd3:  if (ib == 0) begin r = 255; e.err = 1'b1; end else r = ia / ib;
      4'd4:  begin r = ia * 2; e.c = (ia >= 128); end
      4'd5:  begin r = ia / 2; e.c = ((ia % 2) == 1); end
      4'd6:  r = ia * 2 + ia / 128;
      4'd7:  r = ia / 2 + (ia % 2) * 128;
      4'd8:  r = ia & ib;
      4'd9:  r = ia | ib;
      4'd10: r = ia ^ ib;
      4'd11: r = ~(ia | ib);
      4'd12: r = ~(ia & ib);
      4'd13: r = ~(ia ^ ib);
      4'd14: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    e.out = r[7:0];
    e.z   = (e.out == 8'h00);
    return e;
  endfunction

  // Monitor: pops one expectation per output handshake, and checks holding.
  initial begin
    res_t       e;
    bit         hold_prev = 1'b0;
    logic [11:0] prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (hold_prev)
          chk("hold_stable", {20'd0, out_valid, Err, Zero, CarryOut, ALU_Out}, {20'd0, prev});
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0h, expected none", ALU_Out);
          end else begin
            e = sb_q.pop_front();
            chk("result", {21'd0, Err, Zero, CarryOut, ALU_Out}, {21'd0, e});
          end
        end
        hold_prev = out_valid && !out_ready;
        prev      = {out_valid, Err, Zero, CarryOut, ALU_Out};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  // Entered and left at posedge+1. lat >= 0 measures edges until out_valid.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                       input res_t exp, input int lat, output int waited);
    int n;
    A = a; B = b; ALU_Sel = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    waited = n;
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else sb_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom); ALU_Sel = 4'($urandom);
    if (lat >= 0) begin
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        n++;
        @(negedge clk);
      end
      chk("latency", n, lat);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   w;
    int   n;
    res_t e;
    logic [7:0] a, b;
    logic [3:0] s;

    rst_n = 1'b0; A = '0; B = '0; ALU_Sel = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, ALU_Out, CarryOut, Zero, Err, out_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table sweep with A=AA, B=55.
    for (int i = 0; i < 16; i++) begin
      e = '0;
      e.out = tbl_out[i];
      e.c   = tbl_c[i];
      e.z   = (tbl_out[i] == 8'h00);
      issue(8'hAA, 8'h55, 4'(i), e, (i == 2 || i == 3) ? WIDTH : 0, w);
    end

    issue(8'hFF, 8'h01, 4'd0, res_t'({1'b0, 1'b1, 1'b1, 8'h00}), 0, w);
    issue(8'h10, 8'h10, 4'd2, res_t'({1'b0, 1'b1, 1'b1, 8'h00}), WIDTH, w);
    issue(8'h37, 8'h00, 4'd3, res_t'({1'b1, 1'b0, 1'b0, 8'hFF}), 0, w);
    issue(8'h37, 8'h05, 4'd3, res_t'({1'b0, 1'b0, 1'b0, 8'h0B}), WIDTH, w);

    // Backpressure, then swap old result out and new op in on one edge.
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 4'd0, model(8'h12, 8'h34, 4'd0), 0, w);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready || !out_valid) n++;
    end
    chk("backpressure_hold", n, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(8'h3C, 8'h0F, 4'd10, model(8'h3C, 8'h0F, 4'd10), 0, w);
    chk("swap_no_wait", w, 0);

    // Back-to-back single-cycle ops with out_ready high.
    n = 0;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 4'(4 + i);
      issue(a, b, s, model(a, b, s), -1, w);
      n += w;
    end
    chk("throughput_waits", n, 0);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset three cycles into a MUL.
    issue(8'h0F, 8'h0E, 4'd2, model(8'h0F, 8'h0E, 4'd2), -1, w);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    chk("midbusy_reset", {27'd0, ALU_Out, CarryOut, Zero, Err, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_stale_result", n, 0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and idle gaps.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      s = 4'($urandom);
      issue(a, b, s, model(a, b, s), -1, w);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
